// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder: valid/ready word intake, one-word holding buffer,
// and a valid-qualified one-bit-per-cycle output stream with stall and flush.
module bit_stream_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] word_i,
  input  logic             word_valid_i,
  output logic             word_ready_o,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic             d_o,
  output logic             word_done_o,
  output logic             busy_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] pend_q;
  logic [CW-1:0]    cnt_q;
  logic             pend_full_q;
  logic             done_q;

  logic sh_full;
  logic consume;
  logic last_bit;
  logic sh_free;
  logic accept;
  logic out_bit;

  assign sh_full  = (state_q == SHIFT);
  assign consume  = sh_full & ~stall_i;
  assign last_bit = consume & (cnt_q == LAST_CNT);
  // The shifter can take a new word at this edge if empty or draining its last bit.
  assign sh_free  = ~sh_full | last_bit;
  assign accept   = word_valid_i & ~pend_full_q;
  assign out_bit  = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];

  assign word_ready_o = ~pend_full_q;
  assign busy_o       = sh_full | pend_full_q;
  assign valid_o      = consume;
  assign d_o          = sh_full & out_bit;
  assign word_done_o  = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      pend_q      <= '0;
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (flush_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= last_bit;
      if (sh_free) begin
        cnt_q <= '0;
        if (pend_full_q) begin
          sh_q        <= pend_q;
          pend_full_q <= 1'b0;
          state_q     <= SHIFT;
        end else if (accept) begin
          sh_q    <= word_i;
          state_q <= SHIFT;
        end else begin
          state_q <= IDLE;
        end
      end else begin
        if (consume) begin
          cnt_q <= cnt_q + 1'b1;
          if (MSB_FIRST) sh_q <= {sh_q[WIDTH-2:0], 1'b0};
          else           sh_q <= {1'b0, sh_q[WIDTH-1:1]};
        end
        if (accept) begin
          pend_q      <= word_i;
          pend_full_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer: MSB-first and LSB-first instances share stimulus;
// a word-occupancy model predicts handshakes, expected bits are scoreboarded per instance.
module tb_bit_stream_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] word = '0;
  logic         wv = 1'b0, stall = 1'b0, flush = 1'b0;
  logic         ready_m, valid_m, d_m, done_m, busy_m;
  logic         ready_l, valid_l, d_l, done_l, busy_l;

  int unsigned tests = 0, fails = 0;
  int  rem[$];      // bits left for each word held (front = word in shifter)
  bit  expm[$];     // expected bit stream, MSB-first instance
  bit  expl[$];     // expected bit stream, LSB-first instance
  bit  done_exp = 1'b0;

  always #5 clk = ~clk;

  bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .word_i(word), .word_valid_i(wv), .word_ready_o(ready_m),
    .stall_i(stall), .flush_i(flush), .valid_o(valid_m), .d_o(d_m),
    .word_done_o(done_m), .busy_o(busy_m));

  bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk_i(clk), .rst_ni(rst_n), .word_i(word), .word_valid_i(wv), .word_ready_o(ready_l),
    .stall_i(stall), .flush_i(flush), .valid_o(valid_l), .d_o(d_l),
    .word_done_o(done_l), .busy_o(busy_l));

  function automatic void chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every presented bit is popped from the matching scoreboard queue.
  always @(negedge clk) begin
    if (rst_n && valid_m) begin
      if (expm.size() == 0) chk("msb_unexpected_bit", 1'b1, 1'b0);
      else chk("msb_bit", d_m, expm.pop_front());
    end
    if (rst_n && valid_l) begin
      if (expl.size() == 0) chk("lsb_unexpected_bit", 1'b1, 1'b0);
      else chk("lsb_bit", d_l, expl.pop_front());
    end
  end

  function automatic void check_outputs(input logic s);
    bit occ;
    occ = (rem.size() > 0);
    chk("ready_m", ready_m, rem.size() < 2);
    chk("ready_l", ready_l, rem.size() < 2);
    chk("busy_m", busy_m, occ);
    chk("busy_l", busy_l, occ);
    chk("valid_m", valid_m, occ && !s);
    chk("valid_l", valid_l, occ && !s);
    chk("done_m", done_m, done_exp);
    chk("done_l", done_l, done_exp);
    if (!occ) begin
      chk("d_idle_m", d_m, 1'b0);
      chk("d_idle_l", d_l, 1'b0);
    end
  endfunction

  // One clock: drive inputs just after an edge, check, then advance the model at the next edge.
  task automatic cycle(input logic v, input logic [W-1:0] w, input logic s, input logic f);
    bit acc;
    wv = v; word = w; stall = s; flush = f;
    #1;
    check_outputs(s);
    acc = v && (rem.size() < 2) && !f;
    @(posedge clk);
    done_exp = 1'b0;
    if (f) begin
      rem.delete(); expm.delete(); expl.delete();
    end else begin
      if (rem.size() > 0 && !s) begin
        rem[0] = rem[0] - 1;
        if (rem[0] == 0) begin
          void'(rem.pop_front());
          done_exp = 1'b1;
        end
      end
      if (acc) begin
        rem.push_back(W);
        for (int i = 0; i < W; i++) begin
          expm.push_back(w[W-1-i]);
          expl.push_back(w[i]);
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic mid_reset();
    wv = 1'b0; stall = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", valid_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_ready", ready_m, 1'b1);
    chk("rst_d", d_m, 1'b0);
    chk("rst_busy_l", busy_l, 1'b0);
    rem.delete(); expm.delete(); expl.delete();
    done_exp = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_no_done", done_m, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] b2b [3];
    int idx;
    bit r;
    b2b[0] = 8'hFF; b2b[1] = 8'h00; b2b[2] = 8'hA5;

    #3;
    chk("reset_ready", ready_m, 1'b1);
    chk("reset_valid", valid_m, 1'b0);
    chk("reset_busy", busy_m, 1'b0);
    chk("reset_done", done_m, 1'b0);
    chk("reset_d", d_m, 1'b0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // single word
    cycle(1'b1, 8'h68, 1'b0, 1'b0);
    idle(10);

    // back-to-back words offered continuously
    idx = 0;
    while (idx < 3) begin
      r = (rem.size() < 2);
      cycle(1'b1, b2b[idx], 1'b0, 1'b0);
      if (r) idx++;
    end
    idle(26);

    // stall after bit 3
    cycle(1'b1, 8'hB4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    idle(8);

    // backpressure: A in shifter, B in pend, C held until accepted
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    cycle(1'b1, 8'h5E, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'h91, 1'b0, 1'b0);
    idle(20);

    // asynchronous reset during bit 5
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    idle(5);
    mid_reset();
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    idle(10);

    // flush after bit 2 with a word waiting in pend
    cycle(1'b1, 8'h0B, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    idle(10);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      cycle(($urandom % 4) != 0, W'($urandom), ($urandom % 5) == 0, ($urandom % 80) == 0);
    idle(30);

    tests++;
    if (expm.size() != 0 || expl.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d bits left expected 0", expm.size(), expl.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
